// File: rtl/mdu_hilo.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU use shift-add, DIV/DIVU use restoring shift-subtract, 32 iterations each plus one sign-fix cycle.
module mdu_hilo #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             MtHi,
    input  logic             MtLo,
    input  logic [WIDTH-1:0] WData,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = '1;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               is_div;
    logic               sign_a;
    logic               sign_b;

    // acc holds {product hi, product lo / multiplier} or {remainder, quotient / dividend}
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opb;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mul_add;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_acc_nxt;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     div_diff;
    logic               div_ok;
    logic [2*WIDTH-1:0] div_acc_nxt;
    logic [2*WIDTH-1:0] mul_res;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;
    logic               start_ok;

    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                   input logic                    is_signed);
        return (is_signed && v[WIDTH-1]) ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] neg_w(input logic signed [WIDTH-1:0] v,
                                               input logic                    en);
        return en ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic signed [2*WIDTH-1:0] v,
                                                  input logic                      en);
        return en ? -v : v;
    endfunction

    assign start_ok = (state == IDLE) && Start;
    assign Busy     = (state != IDLE);

    assign mag_a = magnitude(A, Op[0]);
    assign mag_b = magnitude(B, Op[0]);

    // Multiply step: conditionally add multiplicand into the upper half, then shift right.
    assign mul_add     = acc[0] ? {1'b0, opb} : '0;
    assign mul_sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + mul_add;
    assign mul_acc_nxt = {mul_sum, acc[WIDTH-1:1]};

    // Divide step: shift next dividend bit into the remainder, keep the difference if it did not borrow.
    assign div_sh      = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_diff    = div_sh - {1'b0, opb};
    assign div_ok      = ~div_diff[WIDTH];
    assign div_acc_nxt = {(div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0]),
                          acc[WIDTH-2:0], div_ok};

    // Sign fix: quotient/product follow sign(A)^sign(B), remainder follows sign(A).
    assign mul_res = neg_2w(acc, sign_a ^ sign_b);
    assign fix_hi  = is_div ? neg_w(acc[2*WIDTH-1:WIDTH], sign_a) : mul_res[2*WIDTH-1:WIDTH];
    assign fix_lo  = is_div ? neg_w(acc[WIDTH-1:0], sign_a ^ sign_b) : mul_res[WIDTH-1:0];

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Start) state_nxt = CALC;
            CALC:    if (cnt == CNT_LAST) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt    <= '0;
            is_div <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            Done   <= 1'b0;
        end else begin
            Done <= (state == FIX);
            if (start_ok) begin
                cnt    <= '0;
                is_div <= Op[1];
                sign_a <= Op[0] & A[WIDTH-1];
                sign_b <= Op[0] & B[WIDTH-1];
            end else if (state == CALC) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (start_ok) begin
            acc <= {{WIDTH{1'b0}}, (Op[1] ? mag_a : mag_b)};
            opb <= Op[1] ? mag_b : mag_a;
        end else if (state == CALC) begin
            acc <= is_div ? div_acc_nxt : mul_acc_nxt;
        end
    end

    // Move-to writes land only while idle; the sign-fix cycle owns HI/LO otherwise.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Hi <= '0;
            Lo <= '0;
        end else if (state == FIX) begin
            Hi <= fix_hi;
            Lo <= fix_lo;
        end else if (state == IDLE) begin
            if (MtHi) Hi <= WData;
            if (MtLo) Lo <= WData;
        end
    end

endmodule

// File: tb/tb_mdu_hilo.sv
// Bench for mdu_hilo: cycle-level reference model of HI/LO, Busy and Done checked every cycle,
// directed scenarios with literal expectations, then randomized operations.
module tb_mdu_hilo;

    logic        Clk;
    logic        Rst;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        MtHi;
    logic        MtLo;
    logic [31:0] WData;
    logic        Busy;
    logic        Done;
    logic [31:0] Hi;
    logic [31:0] Lo;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;
    bit noise  = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [63:0] m_res;
    bit          m_done;
    int          m_remain;

    mdu_hilo #(.WIDTH(32), .CNT_W(5)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
        .MtHi(MtHi), .MtLo(MtLo), .WData(WData),
        .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of one operation, returned as {HI, LO}.
    function automatic logic [63:0] expect_hilo(input logic [1:0] op, input logic [31:0] a,
                                                input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            2'b00: p = {32'b0, a} * {32'b0, b};
            2'b01: p = 64'(sa * sb);
            2'b10: p = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
            default: begin
                if (b == 0) begin
                    p = {a, (a[31] ? 32'h00000001 : 32'hFFFFFFFF)};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
        endcase
        return p;
    endfunction

    // Reference model: an accepted op completes 33 edges later; move-to writes only when idle.
    initial begin
        m_hi = 0; m_lo = 0; m_done = 0; m_remain = 0; m_res = 0;
        forever begin
            @(posedge Clk);
            if (Rst) begin
                m_hi = 0; m_lo = 0; m_done = 0; m_remain = 0;
            end else begin
                m_done = 0;
                if (m_remain > 0) begin
                    m_remain--;
                    if (m_remain == 0) begin
                        {m_hi, m_lo} = m_res;
                        m_done = 1;
                    end
                end else begin
                    if (MtHi) m_hi = WData;
                    if (MtLo) m_lo = WData;
                    if (Start) begin
                        m_res    = expect_hilo(Op, A, B);
                        m_remain = 33;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge Clk);
            if (chk_en) begin
                chk("busy", 32'(Busy), 32'(m_remain > 0));
                chk("done", 32'(Done), 32'(m_done));
                chk("hi", Hi, m_hi);
                chk("lo", Lo, m_lo);
            end
        end
    end

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h00000000;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'h00000001;
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge where Done is seen (or after the bound).
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit interfere, output int lat, output int busy_cnt);
        Start = 1; Op = op; A = a; B = b;
        lat = 0;
        busy_cnt = 0;
        forever begin
            @(negedge Clk);
            lat++;
            Start = 0; MtHi = 0; MtLo = 0;
            if (Busy) busy_cnt++;
            if (Done || lat >= 40) break;
            if (interfere) begin
                if (lat == 5 || lat == 20) begin
                    Start = 1; Op = 2'b11; A = $urandom; B = $urandom;
                end
                if (lat == 10) begin
                    MtLo = 1; WData = 32'h00001234;
                end
                if (lat == 33) begin
                    chk("hold_hi", Hi, 32'hCAFEBABE);
                    chk("hold_lo", Lo, 32'hCAFEBABE);
                end
            end else if (noise && m_remain > 0) begin
                Start = 1'($urandom); Op = 2'($urandom); A = $urandom; B = $urandom;
                MtHi = 1'($urandom); MtLo = 1'($urandom); WData = $urandom;
            end
        end
        chk("done_seen", 32'(Done), 32'd1);
    endtask

    initial begin
        int lat;
        int bc;
        int dcount;
        Rst = 1; Start = 0; Op = 0; A = 0; B = 0; MtHi = 0; MtLo = 0; WData = 0;
        repeat (2) @(negedge Clk);
        chk_en = 1;
        chk("rst_hi", Hi, 32'h0);
        chk("rst_lo", Lo, 32'h0);
        chk("rst_busy", 32'(Busy), 32'h0);
        chk("rst_done", 32'(Done), 32'h0);
        Rst = 0;
        @(negedge Clk);

        run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, lat, bc);
        chk("multu_lat", lat, 34);
        chk("multu_busy_cycles", bc, 33);
        chk("multu_hi", Hi, 32'hFFFFFFFE);
        chk("multu_lo", Lo, 32'h00000001);

        run_op(2'b01, 32'hFFFFFFFD, 32'd7, 0, lat, bc);
        chk("mult_hi", Hi, 32'hFFFFFFFF);
        chk("mult_lo", Lo, 32'hFFFFFFEB);
        run_op(2'b11, 32'hFFFFFFF9, 32'd2, 0, lat, bc);
        chk("div_lo", Lo, 32'hFFFFFFFD);
        chk("div_hi", Hi, 32'hFFFFFFFF);

        run_op(2'b10, 32'd100, 32'd0, 0, lat, bc);
        chk("divu0_lat", lat, 34);
        chk("divu0_lo", Lo, 32'hFFFFFFFF);
        chk("divu0_hi", Hi, 32'd100);
        run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 0, lat, bc);
        chk("divovf_lo", Lo, 32'h80000000);
        chk("divovf_hi", Hi, 32'h0);

        @(negedge Clk);
        MtHi = 1; MtLo = 1; WData = 32'hCAFEBABE;
        @(negedge Clk);
        MtHi = 0; MtLo = 0;
        chk("mt_hi", Hi, 32'hCAFEBABE);
        chk("mt_lo", Lo, 32'hCAFEBABE);
        chk("mt_busy", 32'(Busy), 32'h0);
        chk("mt_done", 32'(Done), 32'h0);

        run_op(2'b00, 32'd1000, 32'd1000, 1, lat, bc);
        chk("intf_lat", lat, 34);
        chk("intf_hi", Hi, 32'h0);
        chk("intf_lo", Lo, 32'h000F4240);

        run_op(2'b10, 32'd17, 32'd5, 0, lat, bc);
        chk("b2b_lat", lat, 34);
        chk("b2b_lo", Lo, 32'd3);
        chk("b2b_hi", Hi, 32'd2);

        Start = 1; Op = 2'b01; A = 32'h12345678; B = 32'h87654321;
        @(negedge Clk);
        Start = 0;
        repeat (9) @(negedge Clk);
        Rst = 1;
        @(negedge Clk);
        Rst = 0;
        chk("abort_busy", 32'(Busy), 32'h0);
        chk("abort_hi", Hi, 32'h0);
        chk("abort_lo", Lo, 32'h0);
        chk("abort_done", 32'(Done), 32'h0);
        dcount = 0;
        repeat (40) begin
            @(negedge Clk);
            if (Done) dcount++;
        end
        chk("abort_no_done", dcount, 0);

        noise = 1;
        for (int i = 0; i < 60; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                MtHi = ($urandom_range(0, 3) == 0);
                MtLo = ($urandom_range(0, 3) == 0);
                WData = $urandom;
                @(negedge Clk);
                MtHi = 0; MtLo = 0;
            end
            MtHi = ($urandom_range(0, 5) == 0);
            MtLo = ($urandom_range(0, 5) == 0);
            WData = $urandom;
            run_op(2'($urandom), pick(), pick(), 0, lat, bc);
            chk("rand_lat", lat, 34);
        end
        noise = 0;
        repeat (3) @(negedge Clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
